// File: rtl/lab_serial_pkg.sv
// Shared types and line constants for the lab serial blocks.
// The PARITY state is always encoded so that all builds share one state type.
package lab_serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-time divider: one-cycle Tick on the last clock of every bit period while En is high.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic En,
    output logic Tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    // Clearing while disabled makes every frame start on a fresh bit period.
    always_ff @(posedge Clk) begin
        if (Reset || !En) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign Tick = En && (count == LAST);

endmodule

// File: rtl/sw_serial_tx.sv
// Serial transmitter: start bit, DATA_W data bits LSB first, stop bit.
// Define SW_SERIAL_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module sw_serial_tx
    import lab_serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Load,
    input  logic [DATA_W-1:0] D,
    output logic              Ready,
    output logic              Busy,
    output logic              TxD
);

    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] LASTBIT = BW'(DATA_W - 1);

    tx_state_t         state;
    logic [DATA_W-1:0] shiftreg;
    logic [DATA_W-1:0] nextshift;
    logic [BW-1:0]     bitcnt;
    logic              baud_en;
    logic              tick;
`ifdef SW_SERIAL_TX_PARITY_EN
    logic              paritybit;
`endif

    assign baud_en   = (state != IDLE);
    assign nextshift = shiftreg >> 1;
    assign Busy      = ~Ready;

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .Clk  (Clk),
        .Reset(Reset),
        .En   (baud_en),
        .Tick (tick)
    );

    // TxD is loaded with the next bit on the boundary tick, so it only moves between bits.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            shiftreg <= '0;
            bitcnt   <= '0;
            TxD      <= LINE_IDLE;
            Ready    <= 1'b1;
`ifdef SW_SERIAL_TX_PARITY_EN
            paritybit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (Load) begin
                        shiftreg <= D;
`ifdef SW_SERIAL_TX_PARITY_EN
                        paritybit <= ^D;
`endif
                        bitcnt   <= '0;
                        state    <= START;
                        TxD      <= START_BIT;
                        Ready    <= 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        state <= DATA;
                        TxD   <= shiftreg[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        shiftreg <= nextshift;
                        if (bitcnt == LASTBIT) begin
                            bitcnt <= '0;
`ifdef SW_SERIAL_TX_PARITY_EN
                            state  <= PARITY;
                            TxD    <= paritybit;
`else
                            state  <= STOP;
                            TxD    <= STOP_BIT;
`endif
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                            TxD    <= nextshift[0];
                        end
                    end
                end
`ifdef SW_SERIAL_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        state <= STOP;
                        TxD   <= STOP_BIT;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        state <= IDLE;
                        TxD   <= LINE_IDLE;
                        Ready <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    bitcnt <= '0;
                    TxD    <= LINE_IDLE;
                    Ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
